// File: rtl/left_shift_rotate_seq_16bit_pkg.sv
// Shared ALU definitions for the iterative left shifter/rotator.
package left_shift_rotate_seq_16bit_pkg;

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic MODE_SHL = 1'b0;
    localparam logic MODE_ROL = 1'b1;

endpackage : left_shift_rotate_seq_16bit_pkg

// File: rtl/left_shift_rotate_seq_16bit.sv
// Iterative left shift / left rotate, one bit position per clock, with start/busy/done handshake.
module left_shift_rotate_seq_16bit
    import left_shift_rotate_seq_16bit_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [CNT_W-1:0] shift,
    input  logic             rotate,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             carry_out
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             carry_out_q, carry_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // State and datapath registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            mode_q      <= MODE_SHL;
            carry_q     <= 1'b0;
            out_q       <= '0;
            carry_out_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            carry_q     <= carry_d;
            out_q       <= out_d;
            carry_out_q <= carry_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic: start only accepted in IDLE; DONE lasts one cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values; busy/done registered from the next state.
    always_comb begin
        work_d      = work_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        carry_d     = carry_q;
        out_d       = out_q;
        carry_out_d = carry_out_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    work_d  = in;
                    cnt_d   = shift;
                    mode_d  = rotate;
                    carry_d = 1'b0;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    work_d  = {work_q[WIDTH-2:0], (mode_q == MODE_ROL) & work_q[WIDTH-1]};
                    carry_d = work_q[WIDTH-1];
                    cnt_d   = cnt_q - CNT_W'(1);
                end else begin
                    out_d       = work_q;
                    carry_out_d = carry_q;
                end
            end
            default: ;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out       = out_q;
    assign carry_out = carry_out_q;

endmodule : left_shift_rotate_seq_16bit

// File: tb/tb_left_shift_rotate_seq_16bit.sv
// Self-checking bench: directed operations against a latency/arithmetic model.
module tb_left_shift_rotate_seq_16bit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] in_v = 16'h0000;
    logic [3:0]  shift_v = 4'h0;
    logic        rotate = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] out_v;
    logic        carry_out;

    int checks = 0;
    int failures = 0;

    left_shift_rotate_seq_16bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in        (in_v),
        .shift     (shift_v),
        .rotate    (rotate),
        .busy      (busy),
        .done      (done),
        .out       (out_v),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Result and carry from plain arithmetic: bit 16 of the widened shift is the last bit out.
    function automatic logic [16:0] model_result(input logic [15:0] a, input logic [3:0] n,
                                                 input logic rot);
        logic [31:0] x;
        x = {16'h0000, a} << n;
        if (rot) return {x[16], x[15:0] | x[31:16]};
        return {x[16], x[15:0]};
    endfunction

    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [15:0] m_out = 16'h0000;
    logic        m_carry = 1'b0;
    logic [15:0] m_res = 16'h0000;
    logic        m_rc = 1'b0;
    int          m_rem = 0;

    // Model: accept in idle, done after N+1 further edges, one-cycle done, then idle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_out   <= 16'h0000;
            m_carry <= 1'b0;
            m_rem   <= 0;
        end else if (m_done) begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
        end else if (m_busy) begin
            if (m_rem == 0) begin
                m_out   <= m_res;
                m_carry <= m_rc;
                m_done  <= 1'b1;
            end else begin
                m_rem <= m_rem - 1;
            end
        end else if (start) begin
            m_busy <= 1'b1;
            m_rem  <= int'(shift_v);
            {m_rc, m_res} <= model_result(in_v, shift_v, rotate);
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        check("cyc_busy", 32'(busy), 32'(m_busy));
        check("cyc_done", 32'(done), 32'(m_done));
        check("cyc_out", 32'(out_v), 32'(m_out));
        check("cyc_carry", 32'(carry_out), 32'(m_carry));
    end

    // One operation with literal expectations; inputs scrambled after acceptance.
    task automatic run_op(input logic [15:0] a, input logic [3:0] n, input logic r,
                          input logic [15:0] exp_out, input logic exp_c, input string name);
        int lat;
        @(negedge clk);
        start = 1'b1; in_v = a; shift_v = n; rotate = r;
        @(negedge clk);
        start = 1'b0; in_v = 16'($urandom); shift_v = 4'($urandom); rotate = 1'($urandom);
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
        end
        check({name, "_latency"}, 32'(lat), 32'(n) + 32'd1);
        check({name, "_out"}, 32'(out_v), 32'(exp_out));
        check({name, "_carry"}, 32'(carry_out), 32'(exp_c));
        @(negedge clk);
        check({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int dcount;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out", 32'(out_v), 32'd0);
        check("rst_carry", 32'(carry_out), 32'd0);
        rst_n = 1'b1;

        run_op(16'h8001, 4'd1,  1'b1, 16'h0003, 1'b1, "rol1");
        run_op(16'h8001, 4'd4,  1'b0, 16'h0010, 1'b0, "shl4");
        run_op(16'hABCD, 4'd0,  1'b0, 16'hABCD, 1'b0, "shl0");
        run_op(16'hABCD, 4'd0,  1'b1, 16'hABCD, 1'b0, "rol0");
        run_op(16'h1234, 4'd15, 1'b1, 16'h091A, 1'b0, "rol15");
        run_op(16'h1234, 4'd15, 1'b0, 16'h0000, 1'b0, "shl15");
        run_op(16'h4000, 4'd2,  1'b0, 16'h0000, 1'b1, "shl2c");
        run_op(16'hC003, 4'd3,  1'b1, 16'h001E, 1'b0, "rol3");

        // start held high with a changing operand: accepts every N+3 cycles.
        @(negedge clk);
        start = 1'b1; shift_v = 4'd2; rotate = 1'b0; in_v = 16'h8421;
        dcount = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (done) dcount++;
            in_v = 16'($urandom);
        end
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("hold_done_count", 32'(dcount), 32'd4);

        // Asynchronous reset in the middle of a rotate.
        @(negedge clk);
        start = 1'b1; in_v = 16'hFFFF; shift_v = 4'd8; rotate = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_busy", 32'(busy), 32'd0);
        check("async_done", 32'(done), 32'd0);
        check("async_out", 32'(out_v), 32'd0);
        check("async_carry", 32'(carry_out), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        run_op(16'h0001, 4'd2, 1'b1, 16'h0004, 1'b0, "post_rst");

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_left_shift_rotate_seq_16bit
